conv1d_requant: RTL and testbench

Downstream post-processing stage for the conv1d CFU. Consumes the signed 32-bit accumulator results (bias already added) as a streaming sequence and requantizes each to int8 using TFLite fixed-point rules: quantized multiplier, power-of-two shift, output offset and activation clamp. Packs four results per 32-bit word for write-back through the CFU response path. Holds a 3-stage arithmetic pipeline plus a packing register with valid/ready handshakes on both sides.

---
 rtl/conv1d_requant_if.sv | 22 ++
 rtl/conv1d_requant.sv | 172 +++++++++++++++++
 tb/tb_conv1d_requant.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_requant_if.sv
// Stream bundle for conv1d_requant: accumulators in,
// packed int8 words out, both valid/ready.
interface conv1d_requant_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_bytes
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_bytes
  );
endinterface

// File: rtl/conv1d_requant.sv
// TFLite int32 -> int8 requantizer with 4-byte packer.
// Capture, multiply, round/shift, offset/clamp, then pack.
module conv1d_requant (
  input  logic        clk,
  input  logic        reset_n,
  conv1d_requant_if.slave s,
  input  logic        cfg_we,
  input  logic [31:0] cfg_mult,
  input  logic [5:0]  cfg_shift,
  input  logic [31:0] cfg_out_offset,
  input  logic [7:0]  cfg_act_min,
  input  logic [7:0]  cfg_act_max,
  output logic        busy
);

  logic        adv;
  logic [31:0] mult;
  logic [31:0] off;
  logic [5:0]  shamt;
  logic [7:0]  amin;
  logic [7:0]  amax;

  logic        s0_v, s0_f;
  logic [31:0] s0_x;
  logic        s1_v, s1_f, s1_sat;
  logic signed [63:0] s1_p;
  logic        s2_v, s2_f;
  logic [31:0] s2_r;
  logic        s3_v, s3_f;
  logic [7:0]  s3_b;
  logic [1:0]  cnt;
  logic [23:0] pend;

  assign adv = !(s.out_valid && !s.out_ready);
  assign s.in_ready = adv;

  assign busy = s0_v | s0_f | s1_v | s1_f |
                s2_v | s2_f | s3_v | s3_f |
                (cnt != 2'd0) | s.out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult  <= 32'h4000_0000;
      shamt <= 6'd0;
      off   <= 32'd0;
      amin  <= 8'h80;
      amax  <= 8'h7F;
    end else if (cfg_we && !busy) begin
      mult  <= cfg_mult;
      shamt <= cfg_shift;
      off   <= cfg_out_offset;
      amin  <= cfg_act_min;
      amax  <= cfg_act_max;
    end
  end

  logic [31:0] x_in;
  logic signed [63:0] prod;
  logic        sat;

  always_comb begin
    x_in = s.in_data;
    if (!shamt[5] && shamt != 6'd0)
      x_in = s.in_data << shamt[4:0];
    prod = $signed({{32{s0_x[31]}}, s0_x}) *
           $signed({{32{mult[31]}}, mult});
    sat  = (s0_x == 32'h8000_0000) &&
           (mult == 32'h8000_0000);
  end

  logic signed [63:0] nudged;
  logic signed [63:0] hx;
  logic signed [63:0] sh;
  logic [63:0] mask;
  logic [63:0] rem;
  logic [63:0] thr;
  logic [5:0]  e;
  logic [31:0] hm;
  logic [31:0] r2;

  // high-mul rounding, then optional rounding right shift
  always_comb begin
    nudged = s1_p + (s1_p[63] ? -64'sd1073741823
                              : 64'sd1073741824);
    hm   = s1_sat ? 32'h7FFF_FFFF : nudged[62:31];
    e    = ~shamt + 6'd1;
    hx   = {{32{hm[31]}}, hm};
    mask = (64'd1 << e) - 64'd1;
    rem  = hx & mask;
    thr  = (mask >> 1) + {63'd0, hm[31]};
    sh   = hx >>> e;
    r2   = hm;
    if (shamt[5])
      r2 = sh[31:0] + {31'd0, rem > thr};
  end

  logic signed [32:0] sum;
  logic signed [32:0] lo;
  logic signed [32:0] hi;
  logic [7:0] b3;

  always_comb begin
    sum = $signed({s2_r[31], s2_r}) +
          $signed({off[31], off});
    lo  = $signed({{25{amin[7]}}, amin});
    hi  = $signed({{25{amax[7]}}, amax});
    b3  = sum[7:0];
    if (sum < lo)
      b3 = amin;
    else if (sum > hi)
      b3 = amax;
  end

  logic unused_bits;
  assign unused_bits = ^{nudged[63], nudged[30:0],
                         sh[63:32]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_v <= 1'b0; s0_f <= 1'b0; s0_x <= '0;
      s1_v <= 1'b0; s1_f <= 1'b0; s1_sat <= 1'b0;
      s1_p <= '0;
      s2_v <= 1'b0; s2_f <= 1'b0; s2_r <= '0;
      s3_v <= 1'b0; s3_f <= 1'b0; s3_b <= '0;
    end else if (adv) begin
      s0_v <= s.in_valid; s0_f <= s.flush;
      s0_x <= x_in;
      s1_v <= s0_v; s1_f <= s0_f;
      s1_p <= prod; s1_sat <= sat;
      s2_v <= s1_v; s2_f <= s1_f; s2_r <= r2;
      s3_v <= s2_v; s3_f <= s2_f; s3_b <= b3;
    end
  end

  logic [2:0]  nb;
  logic [31:0] word;
  logic        emit;

  // pending bytes above cnt are kept zero
  always_comb begin
    nb   = {1'b0, cnt} + {2'b0, s3_v};
    word = {8'h00, pend};
    if (s3_v)
      word = word | ({24'd0, s3_b} << {cnt, 3'b000});
    emit = (nb == 3'd4) || (s3_f && nb != 3'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= 2'd0;
      pend        <= '0;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_bytes <= 3'd0;
    end else if (adv) begin
      if (emit) begin
        s.out_data  <= word;
        s.out_bytes <= nb;
        s.out_valid <= 1'b1;
        cnt         <= 2'd0;
        pend        <= '0;
      end else begin
        s.out_valid <= 1'b0;
        if (s3_v) begin
          cnt  <= nb[1:0];
          pend <= word[23:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv1d_requant.sv
// Directed + random bench for conv1d_requant against
// an arithmetic reference model of the requant rules.
module tb_conv1d_requant;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_we;
  logic [31:0] cfg_mult;
  logic [5:0]  cfg_shift;
  logic [31:0] cfg_out_offset;
  logic [7:0]  cfg_act_min;
  logic [7:0]  cfg_act_max;
  logic        busy;

  conv1d_requant_if bus();

  conv1d_requant dut (
    .clk(clk),
    .reset_n(reset_n),
    .s(bus.slave),
    .cfg_we(cfg_we),
    .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift),
    .cfg_out_offset(cfg_out_offset),
    .cfg_act_min(cfg_act_min),
    .cfg_act_max(cfg_act_max),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int n_words = 0;
  bit bp = 1'b0;

  int m_mult, m_shift, m_off, m_min, m_max;
  logic [7:0]  pend[$];
  logic [31:0] expw[$];
  logic [2:0]  expb[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_mult = 32'h4000_0000;
    m_shift = 0; m_off = 0;
    m_min = -128; m_max = 127;
    pend.delete(); expw.delete(); expb.delete();
  endfunction

  // round half away from zero of n/d
  function automatic longint rhaz(longint n, longint d);
    longint a, q;
    a = (n < 0) ? -n : n;
    q = a / d;
    if (2 * (a % d) >= d) q++;
    return (n < 0) ? -q : q;
  endfunction

  function automatic logic [7:0] model_byte(int acc);
    int x;
    longint hm, v;
    x = (m_shift > 0) ? (acc << m_shift) : acc;
    if (x == 32'h8000_0000 && m_mult == 32'h8000_0000)
      hm = 64'sd2147483647;
    else
      hm = rhaz(longint'(x) * longint'(m_mult),
                64'sd2147483648);
    if (m_shift < 0)
      hm = rhaz(hm, longint'(1) << (-m_shift));
    v = hm + longint'(m_off);
    if (v < m_min) v = m_min;
    else if (v > m_max) v = m_max;
    return v[7:0];
  endfunction

  function automatic void m_emit();
    logic [31:0] w;
    w = '0;
    foreach (pend[i]) w[8*i +: 8] = pend[i];
    expw.push_back(w);
    expb.push_back(3'(pend.size()));
    pend.delete();
  endfunction

  // one clock: starts and ends just after a negedge
  task automatic cycle(output bit acc);
    logic [31:0] w;
    logic [2:0]  b;
    bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    chk("in_ready", 32'(bus.in_ready),
        32'(!(bus.out_valid && !bus.out_ready)));
    acc = bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      n_words++;
      if (expw.size() == 0) begin
        chk("unexpected_word", 32'(bus.out_valid), 0);
      end else begin
        w = expw.pop_front();
        b = expb.pop_front();
        chk("word_data", bus.out_data, w);
        chk("word_bytes", 32'(bus.out_bytes), 32'(b));
      end
    end
    if (acc && bus.in_valid) begin
      pend.push_back(model_byte(bus.in_data));
      if (pend.size() == 4) m_emit();
    end
    if (acc && bus.flush && pend.size() > 0) m_emit();
    @(negedge clk);
  endtask

  task automatic send(logic [31:0] d, bit v, bit f);
    bit a;
    int n;
    n = 0;
    bus.in_data = d; bus.in_valid = v; bus.flush = f;
    do begin
      cycle(a);
      n++;
    end while (!a && n < 100);
    chk("send_accept", 32'(a), 1);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while ((expw.size() > 0 || bus.out_valid) && n < 300) begin
      cycle(a);
      n++;
    end
    chk("drain_left", expw.size(), 0);
  endtask

  task automatic expect_word(logic [31:0] d, logic [2:0] b);
    bit a;
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      cycle(a);
      n++;
    end
    chk("dir_data", bus.out_data, d);
    chk("dir_bytes", 32'(bus.out_bytes), 32'(b));
  endtask

  task automatic set_cfg(int mu, int sh, int of,
                         int mn, int mx, bit apply);
    bit a;
    cfg_mult = mu; cfg_shift = sh[5:0];
    cfg_out_offset = of;
    cfg_act_min = mn[7:0]; cfg_act_max = mx[7:0];
    cfg_we = 1'b1;
    cycle(a);
    cfg_we = 1'b0;
    if (apply) begin
      m_mult = mu; m_shift = sh; m_off = of;
      m_min = mn; m_max = mx;
    end
  endtask

  initial begin
    bit a;
    int n, nw0;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b1;
    cfg_we = 1'b0; cfg_mult = '0; cfg_shift = '0;
    cfg_out_offset = '0; cfg_act_min = '0;
    cfg_act_max = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_bytes", 32'(bus.out_bytes), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    send(50, 1, 0); send(60, 1, 0);
    send(69, 1, 0); send(77, 1, 0);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      cycle(a);
      n++;
    end
    chk("latency", n, 4);
    chk("t1_data", bus.out_data, 32'h2723_1E19);
    chk("t1_bytes", 32'(bus.out_bytes), 4);
    drain();

    nw0 = n_words;
    send(84, 1, 0); send(70, 1, 0);
    send(57, 1, 0); send(45, 1, 0);
    send(0, 0, 1);
    expect_word(32'h171D_232A, 3'd4);
    drain();
    repeat (8) cycle(a);
    chk("flush_no_extra", n_words - nw0, 1);
    chk("idle_busy", 32'(busy), 0);

    set_cfg(32'h4000_0000, -2, -128, -128, 127, 1);
    send(100, 1, 0); send(101, 1, 0); send(102, 1, 1);
    expect_word(32'h008D_8D8D, 3'd3);
    drain();

    set_cfg(32'h8000_0000, 0, 0, -128, 127, 1);
    send(32'h8000_0000, 1, 1);
    expect_word(32'h0000_007F, 3'd1);
    drain();
    set_cfg(32'h7FFF_FFFF, 0, 0, -128, 127, 1);
    send(32'h8000_0000, 1, 1);
    expect_word(32'h0000_0080, 3'd1);
    drain();
    set_cfg(32'h4000_0000, 0, 0, 0, 6, 1);
    send(-5, 1, 0); send(200, 1, 1);
    expect_word(32'h0000_0600, 3'd2);
    drain();

    set_cfg(int'($urandom), int'($urandom_range(0, 16)) - 8,
            int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 127)) - 128,
            int'($urandom_range(0, 127)), 1);
    nw0 = n_words;
    bp = 1'b1;
    for (int i = 0; i < 16; i++)
      send($urandom, 1, 0);
    send(0, 0, 1);
    drain();
    bp = 1'b0;
    chk("bp_words", n_words - nw0, 4);

    set_cfg(32'h5A5A_0000, 3, 17, -100, 90, 1);
    send($urandom_range(0, 65535), 1, 0);
    chk("busy_streaming", 32'(busy), 1);
    set_cfg(32'h1234_5678, -7, -50, -10, 10, 0);
    for (int i = 0; i < 3; i++)
      send($urandom_range(0, 65535), 1, 0);
    drain();
    for (int i = 0; i < 4; i++)
      send($urandom, 1, 0);
    drain();

    send(1000, 1, 0); send(2000, 1, 0); send(3000, 1, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    nw0 = n_words;
    for (int i = 0; i < 4; i++)
      send($urandom_range(0, 400), 1, 0);
    drain();
    repeat (6) cycle(a);
    chk("post_rst_words", n_words - nw0, 1);
    chk("post_rst_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
